// File: rtl/block_xfer_seq_if.sv
// ============================================================================
// block_xfer_seq_if : control, register-file and memory bundle for block_xfer_seq
// Optional: BLOCK_XFER_ABORT_EN adds mem_abort_i / abort_o.          Rev 1.0
// ============================================================================
`default_nettype none

interface block_xfer_seq_if #(
   parameter int AW = 32
);
   logic          start_i;
   logic [15:0]   reglist_i;
   logic [3:0]    rn_i;
   logic [AW-1:0] base_i;
   logic          up_i;
   logic          pre_i;
   logic          load_i;
   logic          wb_i;
   logic [3:0]    ra_o;
   logic [AW-1:0] rd_i;
   logic          we_o;
   logic [3:0]    wa_o;
   logic [AW-1:0] wd_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [AW-1:0] mem_wdata_o;
   logic [AW-1:0] mem_rdata_i;
   logic          mem_ack_i;
   logic          busy_o;
   logic          done_o;
`ifdef BLOCK_XFER_ABORT_EN
   logic          mem_abort_i;
   logic          abort_o;
`endif

   modport master (
      input  start_i, reglist_i, rn_i, base_i, up_i, pre_i, load_i, wb_i,
      input  rd_i, mem_rdata_i, mem_ack_i,
`ifdef BLOCK_XFER_ABORT_EN
      input  mem_abort_i,
      output abort_o,
`endif
      output ra_o, we_o, wa_o, wd_o, mem_req_o, mem_we_o, mem_addr_o,
      output mem_wdata_o, busy_o, done_o
   );

   modport slave (
      output start_i, reglist_i, rn_i, base_i, up_i, pre_i, load_i, wb_i,
      output rd_i, mem_rdata_i, mem_ack_i,
`ifdef BLOCK_XFER_ABORT_EN
      output mem_abort_i,
      input  abort_o,
`endif
      input  ra_o, we_o, wa_o, wd_o, mem_req_o, mem_we_o, mem_addr_o,
      input  mem_wdata_o, busy_o, done_o
   );
endinterface

`default_nettype wire

// File: rtl/block_xfer_seq.sv
// ============================================================================
// block_xfer_seq : LDM/STM block transfer sequencer with optional base writeback
// Optional: BLOCK_XFER_ABORT_EN enables memory abort handling.       Rev 1.0
// ============================================================================
`default_nettype none

module block_xfer_seq #(
   parameter int AW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   block_xfer_seq_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [AW-1:0] c_word = AW'(4);

   state_t        r_state;
   state_t        w_next;
   logic [15:0]   r_rem;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_wbdata;
   logic [3:0]    r_rn;
   logic          r_load;
   logic          r_wb_en;
`ifdef BLOCK_XFER_ABORT_EN
   logic          r_aborted;
`endif

   logic [4:0]    w_cnt;
   logic [AW-1:0] w_span;
   logic [AW-1:0] w_start_addr;
   logic [3:0]    w_cur;
   logic [15:0]   w_cur_bit;
   logic          w_last;
   logic          w_abort;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
      return c;
   endfunction

   assign w_cnt  = popcount16(bus.reglist_i);
   assign w_span = {{(AW-7){1'b0}}, w_cnt, 2'b00};

   always_comb begin
      case ({bus.up_i, bus.pre_i})
         2'b10:   w_start_addr = bus.base_i;
         2'b11:   w_start_addr = bus.base_i + c_word;
         2'b00:   w_start_addr = bus.base_i - w_span + c_word;
         default: w_start_addr = bus.base_i - w_span;
      endcase
   end

   // Lowest set bit of the remaining list is the register for this beat.
   always_comb begin
      w_cur = '0;
      for (int i = 15; i >= 0; i--) begin
         if (r_rem[i]) w_cur = 4'(i);
      end
   end

   assign w_cur_bit = 16'd1 << w_cur;
   assign w_last    = ((r_rem & ~w_cur_bit) == 16'd0);

`ifdef BLOCK_XFER_ABORT_EN
   assign w_abort     = bus.mem_abort_i;
   assign bus.abort_o = (r_state == S_DONE) && r_aborted;
`else
   assign w_abort     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      bus.busy_o      = (r_state != S_IDLE);
      bus.done_o      = 1'b0;
      bus.mem_req_o   = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      bus.ra_o        = '0;
      bus.we_o        = 1'b0;
      bus.wa_o        = '0;
      bus.wd_o        = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.start_i) w_next = (bus.reglist_i == 16'd0) ? S_DONE : S_XFER;
         end
         S_XFER: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_we_o   = ~r_load;
            bus.mem_addr_o = r_addr;
            if (!r_load) begin
               bus.ra_o        = w_cur;
               bus.mem_wdata_o = bus.rd_i;
            end
            if (bus.mem_ack_i) begin
               if (w_abort) begin
                  w_next = S_DONE;
               end else begin
                  if (r_load) begin
                     bus.we_o = 1'b1;
                     bus.wa_o = w_cur;
                     bus.wd_o = bus.mem_rdata_i;
                  end
                  if (w_last) w_next = r_wb_en ? S_WB : S_DONE;
               end
            end
         end
         S_WB: begin
            bus.we_o = 1'b1;
            bus.wa_o = r_rn;
            bus.wd_o = r_wbdata;
            w_next   = S_DONE;
         end
         default: begin
            bus.done_o = 1'b1;
            w_next     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem    <= '0;
         r_addr   <= '0;
         r_wbdata <= '0;
         r_rn     <= '0;
         r_load   <= 1'b0;
         r_wb_en  <= 1'b0;
      end else if (r_state == S_IDLE && bus.start_i) begin
         r_rem    <= bus.reglist_i;
         r_addr   <= w_start_addr;
         r_wbdata <= bus.up_i ? (bus.base_i + w_span) : (bus.base_i - w_span);
         r_rn     <= bus.rn_i;
         r_load   <= bus.load_i;
         // A load that includes the base register owns it; no writeback.
         r_wb_en  <= bus.wb_i && !(bus.load_i && bus.reglist_i[bus.rn_i]);
      end else if (r_state == S_XFER && bus.mem_ack_i) begin
         r_rem  <= r_rem & ~w_cur_bit;
         r_addr <= r_addr + c_word;
      end
   end

`ifdef BLOCK_XFER_ABORT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    r_aborted <= 1'b0;
      else if (r_state == S_IDLE && bus.start_i)     r_aborted <= 1'b0;
      else if (r_state == S_XFER && bus.mem_ack_i && bus.mem_abort_i)
                                                     r_aborted <= 1'b1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_xfer_seq.sv
// ============================================================================
// tb_block_xfer_seq : table-driven block transfer vectors plus reset/abort runs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_block_xfer_seq;

   localparam int AW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   block_xfer_seq_if #(.AW(AW)) bus ();

   block_xfer_seq #(.AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register file read model: value identifies the register read.
   assign bus.rd_i = 32'hCAFE_0000 | {28'd0, bus.ra_o};

   typedef struct {
      logic [15:0] reglist;
      logic [31:0] base;
      logic [3:0]  rn;
      logic        up;
      logic        pre;
      logic        load;
      logic        wb;
      int          delay;
      logic [31:0] exp_first;
      logic        exp_wb;
      logic [31:0] exp_wbdata;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_xfer(input vec_t v, input int abort_beat);
      int         n;
      logic [3:0] regs[16];
      logic [31:0] a;
      logic       ack;
      logic       aborted;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         regs[i] = '0;
         if (v.reglist[i]) begin
            regs[n] = 4'(i);
            n++;
         end
      end
      @(negedge clk);
      check("idle_busy", bus.busy_o, 0);
      bus.start_i   = 1'b1;
      bus.reglist_i = v.reglist;
      bus.base_i    = v.base;
      bus.rn_i      = v.rn;
      bus.up_i      = v.up;
      bus.pre_i     = v.pre;
      bus.load_i    = v.load;
      bus.wb_i      = v.wb;
      @(negedge clk);
      // Operands change and start stays high while busy; none of it may matter.
      bus.reglist_i = 16'hFFFF;
      bus.base_i    = 32'hDEAD_BEEF;
      bus.rn_i      = ~v.rn;
      bus.up_i      = ~v.up;
      bus.pre_i     = ~v.pre;
      bus.load_i    = ~v.load;
      bus.wb_i      = ~v.wb;
      aborted = 1'b0;
      for (int k = 0; k < n && !aborted; k++) begin
         for (int w = 0; w <= v.delay; w++) begin
            ack = (w == v.delay);
            a   = v.exp_first + 32'(4 * k);
            bus.mem_ack_i   = ack;
            bus.mem_rdata_i = ack ? mdata(a) : 32'h0;
`ifdef BLOCK_XFER_ABORT_EN
            bus.mem_abort_i = ack && (k == abort_beat);
`endif
            #1;
            check("xfer_busy", bus.busy_o, 1);
            check("mem_req", bus.mem_req_o, 1);
            check("mem_addr", bus.mem_addr_o, a);
            check("mem_we", bus.mem_we_o, !v.load);
            check("xfer_done", bus.done_o, 0);
            if (!v.load) begin
               check("ra", bus.ra_o, regs[k]);
               check("mem_wdata", bus.mem_wdata_o, 32'hCAFE_0000 | {28'd0, regs[k]});
            end
            if (v.load && ack && k != abort_beat) begin
               check("ld_we", bus.we_o, 1);
               check("ld_wa", bus.wa_o, regs[k]);
               check("ld_wd", bus.wd_o, mdata(a));
            end else begin
               check("xfer_we", bus.we_o, 0);
            end
            @(negedge clk);
         end
         if (k == abort_beat) aborted = 1'b1;
      end
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
`ifdef BLOCK_XFER_ABORT_EN
      bus.mem_abort_i = 1'b0;
`endif
      #1;
      if (v.exp_wb && !aborted) begin
         check("wb_we", bus.we_o, 1);
         check("wb_wa", bus.wa_o, v.rn);
         check("wb_wd", bus.wd_o, v.exp_wbdata);
         check("wb_req", bus.mem_req_o, 0);
         check("wb_done", bus.done_o, 0);
         @(negedge clk);
         #1;
      end
      check("done", bus.done_o, 1);
      check("done_busy", bus.busy_o, 1);
      check("done_we", bus.we_o, 0);
      check("done_req", bus.mem_req_o, 0);
`ifdef BLOCK_XFER_ABORT_EN
      check("abort_o", bus.abort_o, aborted);
`endif
      bus.start_i = 1'b0;
      @(negedge clk);
      #1;
      check("end_busy", bus.busy_o, 0);
      check("end_done", bus.done_o, 0);
      check("end_req", bus.mem_req_o, 0);
   endtask

   initial begin
      vec_t ab;
      //            reglist   base          rn   U     P     L     W   dly first         wb    wbdata
      vecs[0] = '{16'h000E, 32'h0000_1000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_1000, 1'b0, 32'h0};
      vecs[1] = '{16'h0021, 32'h0000_2000, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 2, 32'h0000_1FF8, 1'b1, 32'h0000_1FF8};
      vecs[2] = '{16'h0004, 32'h0000_4000, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0000_4000, 1'b0, 32'h0};
      vecs[3] = '{16'h0000, 32'h0000_7000, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 32'h0,         1'b0, 32'h0};
      vecs[4] = '{16'h8001, 32'h0000_0100, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0000_00FC, 1'b1, 32'h0000_00F8};
      vecs[5] = '{16'h00F0, 32'h0000_0500, 4'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1, 32'h0000_0504, 1'b1, 32'h0000_0510};
      vecs[6] = '{16'h0003, 32'h0000_0004, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC};
      vecs[7] = '{16'hFFFF, 32'h0000_0000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0000, 1'b0, 32'h0};

      bus.start_i     = 1'b0;
      bus.reglist_i   = '0;
      bus.rn_i        = '0;
      bus.base_i      = '0;
      bus.up_i        = 1'b0;
      bus.pre_i       = 1'b0;
      bus.load_i      = 1'b0;
      bus.wb_i        = 1'b0;
      bus.mem_rdata_i = '0;
      bus.mem_ack_i   = 1'b0;
`ifdef BLOCK_XFER_ABORT_EN
      bus.mem_abort_i = 1'b0;
`endif

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_req", bus.mem_req_o, 0);
      check("rst_mem_we", bus.mem_we_o, 0);
      check("rst_we", bus.we_o, 0);
      check("rst_ra", bus.ra_o, 0);
      check("rst_wa", bus.wa_o, 0);
      check("rst_wd", bus.wd_o, 0);
      check("rst_addr", bus.mem_addr_o, 0);
      check("rst_wdata", bus.mem_wdata_o, 0);
`ifdef BLOCK_XFER_ABORT_EN
      check("rst_abort", bus.abort_o, 0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_xfer(vecs[i], -1);

      // Reset during the second beat of a 4-register STM.
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.reglist_i = 16'h000F;
      bus.base_i    = 32'h0000_0800;
      bus.up_i      = 1'b1;
      bus.pre_i     = 1'b0;
      bus.load_i    = 1'b0;
      bus.wb_i      = 1'b1;
      bus.rn_i      = 4'd6;
      @(negedge clk);
      bus.start_i   = 1'b0;
      bus.mem_ack_i = 1'b1;
      #1;
      check("rs_beat0_addr", bus.mem_addr_o, 32'h0000_0800);
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      check("rs_beat1_req", bus.mem_req_o, 1);
      check("rs_beat1_addr", bus.mem_addr_o, 32'h0000_0804);
      rst_n = 1'b0;
      #1;
      check("rs_req", bus.mem_req_o, 0);
      check("rs_busy", bus.busy_o, 0);
      check("rs_we", bus.we_o, 0);
      check("rs_addr", bus.mem_addr_o, 0);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("rs_hold_req", bus.mem_req_o, 0);
         check("rs_hold_we", bus.we_o, 0);
      end
      rst_n = 1'b1;
      run_xfer(vecs[0], -1);

`ifdef BLOCK_XFER_ABORT_EN
      ab = '{16'h0F00, 32'h0000_3000, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 32'h0000_3004, 1'b1, 32'h0000_3010};
      run_xfer(ab, 1);
      run_xfer(vecs[1], -1);
`else
      ab = vecs[0];
      run_xfer(ab, -1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
